// File: rtl/demux_1_2_reg.sv
// demux_1_2_reg
// Registered 1-to-2 word demultiplexer. One word per cycle arrives from a
// single producer over valid/ready and is steered by in_sel into one of two
// one-entry output slots (A = 0, B = 1). Each slot has its own handshake, so a
// stalled sink only blocks words that are headed for that same sink.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_data/in_sel/in_valid   producer word, destination select, word present
//   in_ready                  word accepted this cycle (combinational)
//   out_a_data/valid/ready    slot A word, slot A full, A sink consumes
//   out_b_data/valid/ready    slot B word, slot B full, B sink consumes
//   cnt_a, cnt_b              wrapping counts of words delivered to A and B

module demux_1_2_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_a_data,
   output logic             out_a_valid,
   input  logic             out_a_ready,
   output logic [WIDTH-1:0] out_b_data,
   output logic             out_b_valid,
   input  logic             out_b_ready,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   // Slot 0 is A, slot 1 is B.
   logic             valid_q [2];
   logic             valid_d [2];
   logic [WIDTH-1:0] data_q  [2];
   logic [WIDTH-1:0] data_d  [2];
   logic [CNT_W-1:0] cnt_q   [2];
   logic [CNT_W-1:0] cnt_d   [2];

   logic [1:0] sink_ready;
   logic [1:0] slot_sel;
   logic [1:0] can_take;
   logic [1:0] load;
   logic [1:0] drain;

   assign sink_ready = {out_b_ready, out_a_ready};
   assign slot_sel   = {in_sel, ~in_sel};

   // in_ready only looks at the addressed slot; it never depends on in_valid.
   assign in_ready = in_sel ? can_take[1] : can_take[0];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         // A full slot whose sink is consuming this cycle can still take a
         // word, which gives back-to-back throughput with no bubble.
         assign can_take[gi] = !valid_q[gi] || sink_ready[gi];
         assign load[gi]     = in_valid && in_ready && slot_sel[gi];
         assign drain[gi]    = valid_q[gi] && sink_ready[gi];

         always_comb begin
            valid_d[gi] = valid_q[gi];
            data_d[gi]  = data_q[gi];
            cnt_d[gi]   = cnt_q[gi];
            if (load[gi]) begin
               valid_d[gi] = 1'b1;
               data_d[gi]  = in_data;
            end else if (drain[gi]) begin
               // Data register keeps the drained word; only valid drops.
               valid_d[gi] = 1'b0;
            end
            if (drain[gi]) begin
               cnt_d[gi] = cnt_q[gi] + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q[gi] <= 1'b0;
               data_q[gi]  <= '0;
               cnt_q[gi]   <= '0;
            end else begin
               valid_q[gi] <= valid_d[gi];
               data_q[gi]  <= data_d[gi];
               cnt_q[gi]   <= cnt_d[gi];
            end
         end
      end
   endgenerate

   assign out_a_valid = valid_q[0];
   assign out_a_data  = data_q[0];
   assign cnt_a       = cnt_q[0];
   assign out_b_valid = valid_q[1];
   assign out_b_data  = data_q[1];
   assign cnt_b       = cnt_q[1];

endmodule

// File: tb/tb_demux_1_2_reg.sv
module tb_demux_1_2_reg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_a_data;
   logic             out_a_valid;
   logic             out_a_ready;
   logic [WIDTH-1:0] out_b_data;
   logic             out_b_valid;
   logic             out_b_ready;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   int checks = 0;
   int errors = 0;

   demux_1_2_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_sel      (in_sel),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_a_data  (out_a_data),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_b_data  (out_b_data),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready),
      .cnt_a       (cnt_a),
      .cnt_b       (cnt_b)
   );

   always #5 clk = ~clk;

   // One line per transaction seen at a clock edge.
   always @(posedge clk) begin
      if (!rst && in_valid && in_ready)
         $display("[%0t] accept sel=%0d data=%08h", $time, in_sel, in_data);
      if (!rst && out_a_valid && out_a_ready)
         $display("[%0t] deliver A data=%08h", $time, out_a_data);
      if (!rst && out_b_valid && out_b_ready)
         $display("[%0t] deliver B data=%08h", $time, out_b_data);
   end

   // Advance one clock edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      out_a_ready = 1'b0; out_b_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      checks++; if (out_a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %0b exp 0", out_a_valid); end
      checks++; if (out_b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid got %0b exp 0", out_b_valid); end
      checks++; if (out_a_data !== 32'h0) begin errors++; $display("FAIL reset_a_data got %08h exp 0", out_a_data); end
      checks++; if (out_b_data !== 32'h0) begin errors++; $display("FAIL reset_b_data got %08h exp 0", out_b_data); end
      checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_cnt_a got %0d exp 0", cnt_a); end
      checks++; if (cnt_b !== 4'd0) begin errors++; $display("FAIL reset_cnt_b got %0d exp 0", cnt_b); end
      in_sel = 1'b0; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_sel0 got %0b exp 1", in_ready); end
      in_sel = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_sel1 got %0b exp 1", in_ready); end
   endtask

   task automatic test_single();
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      in_data = 32'hDEADBEEF; in_sel = 1'b0; in_valid = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_a got %0b exp 1", in_ready); end
      tick();
      checks++; if (out_a_valid !== 1'b1) begin errors++; $display("FAIL single_a_valid got %0b exp 1", out_a_valid); end
      checks++; if (out_a_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_a_data got %08h exp deadbeef", out_a_data); end
      in_data = 32'h12345678; in_sel = 1'b1;
      tick();
      checks++; if (out_b_valid !== 1'b1) begin errors++; $display("FAIL single_b_valid got %0b exp 1", out_b_valid); end
      checks++; if (out_b_data !== 32'h12345678) begin errors++; $display("FAIL single_b_data got %08h exp 12345678", out_b_data); end
      checks++; if (out_a_valid !== 1'b0) begin errors++; $display("FAIL single_a_drained got %0b exp 0", out_a_valid); end
      checks++; if (cnt_a !== 4'd1) begin errors++; $display("FAIL single_cnt_a got %0d exp 1", cnt_a); end
      in_valid = 1'b0;
      tick();
      checks++; if (cnt_b !== 4'd1) begin errors++; $display("FAIL single_cnt_b got %0d exp 1", cnt_b); end
      checks++; if (out_b_valid !== 1'b0) begin errors++; $display("FAIL single_b_drained got %0b exp 0", out_b_valid); end
      checks++; if (out_a_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_a_data_held got %08h exp deadbeef", out_a_data); end
   endtask

   task automatic test_stream();
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_data = 32'(i); in_sel = 1'b0; in_valid = 1'b1; #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %0b exp 1", i, in_ready); end
         tick();
         checks++; if (out_a_valid !== 1'b1 || out_a_data !== 32'(i))
            begin errors++; $display("FAIL stream_a[%0d] got v=%0b d=%08h exp v=1 d=%08h", i, out_a_valid, out_a_data, i); end
      end
      in_valid = 1'b0;
      tick();
      // 1 earlier delivery plus 8 streamed words.
      checks++; if (cnt_a !== 4'd9) begin errors++; $display("FAIL stream_cnt_a got %0d exp 9", cnt_a); end
      checks++; if (out_a_valid !== 1'b0) begin errors++; $display("FAIL stream_a_empty got %0b exp 0", out_a_valid); end
   endtask

   task automatic test_backpressure();
      out_a_ready = 1'b0; out_b_ready = 1'b0;
      in_data = 32'hAAAA0001; in_sel = 1'b0; in_valid = 1'b1;
      tick();
      checks++; if (out_a_data !== 32'hAAAA0001) begin errors++; $display("FAIL bp_a_first got %08h exp aaaa0001", out_a_data); end
      // Probe B readiness with no word offered.
      in_valid = 1'b0; in_sel = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b_free got %0b exp 1", in_ready); end
      in_data = 32'hAAAA0002; in_sel = 1'b0; in_valid = 1'b1; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_a_stalled got %0b exp 0", in_ready); end
      tick();
      checks++; if (out_a_data !== 32'hAAAA0001 || cnt_a !== 4'd9)
         begin errors++; $display("FAIL bp_a_hold got d=%08h c=%0d exp d=aaaa0001 c=9", out_a_data, cnt_a); end
      out_a_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a_release got %0b exp 1", in_ready); end
      tick();
      out_a_ready = 1'b0;
      checks++; if (out_a_valid !== 1'b1 || out_a_data !== 32'hAAAA0002 || cnt_a !== 4'd10)
         begin errors++; $display("FAIL bp_a_second got v=%0b d=%08h c=%0d exp v=1 d=aaaa0002 c=10", out_a_valid, out_a_data, cnt_a); end
      in_data = 32'hBBBB0001; in_sel = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got %0b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_b_valid !== 1'b1 || out_b_data !== 32'hBBBB0001)
         begin errors++; $display("FAIL bp_b_data got v=%0b d=%08h exp v=1 d=bbbb0001", out_b_valid, out_b_data); end
      checks++; if (out_a_valid !== 1'b1 || out_a_data !== 32'hAAAA0002)
         begin errors++; $display("FAIL bp_a_still_held got v=%0b d=%08h exp v=1 d=aaaa0002", out_a_valid, out_a_data); end
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      tick();
      checks++; if (cnt_a !== 4'd11 || cnt_b !== 4'd2)
         begin errors++; $display("FAIL bp_both_drain got a=%0d b=%0d exp a=11 b=2", cnt_a, cnt_b); end
      checks++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0)
         begin errors++; $display("FAIL bp_both_empty got a=%0b b=%0b exp 0 0", out_a_valid, out_b_valid); end
   endtask

   task automatic test_back_to_back();
      out_a_ready = 1'b0;
      in_data = 32'h11; in_sel = 1'b0; in_valid = 1'b1;
      tick();
      checks++; if (out_a_data !== 32'h11) begin errors++; $display("FAIL b2b_first got %08h exp 00000011", out_a_data); end
      out_a_ready = 1'b1; in_data = 32'h22; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_a_valid !== 1'b1 || out_a_data !== 32'h22 || cnt_a !== 4'd12)
         begin errors++; $display("FAIL b2b_swap got v=%0b d=%08h c=%0d exp v=1 d=00000022 c=12", out_a_valid, out_a_data, cnt_a); end
      tick();
      checks++; if (cnt_a !== 4'd13 || out_a_valid !== 1'b0)
         begin errors++; $display("FAIL b2b_drain got v=%0b c=%0d exp v=0 c=13", out_a_valid, cnt_a); end
   endtask

   task automatic test_wrap();
      rst = 1'b1; in_valid = 1'b0;
      tick();
      rst = 1'b0;
      checks++; if (cnt_b !== 4'd0) begin errors++; $display("FAIL wrap_start got %0d exp 0", cnt_b); end
      out_b_ready = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         in_data = 32'hB000_0000 + 32'(i); in_sel = 1'b1; in_valid = 1'b1;
         tick();
      end
      // 16 words have left the slot so far: counter wrapped to 0.
      checks++; if (cnt_b !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", cnt_b); end
      in_valid = 1'b0;
      tick();
      checks++; if (cnt_b !== 4'd1) begin errors++; $display("FAIL wrap_one got %0d exp 1", cnt_b); end
   endtask

   task automatic test_reset_midflight();
      out_a_ready = 1'b0; out_b_ready = 1'b0;
      in_data = 32'h0000_00A5; in_sel = 1'b0; in_valid = 1'b1;
      tick();
      in_data = 32'h0000_00B5; in_sel = 1'b1;
      tick();
      checks++; if (out_a_valid !== 1'b1 || out_b_valid !== 1'b1)
         begin errors++; $display("FAIL mid_fill got a=%0b b=%0b exp 1 1", out_a_valid, out_b_valid); end
      rst = 1'b1; out_a_ready = 1'b1; out_b_ready = 1'b1;
      in_data = 32'h0000_0055; in_sel = 1'b0;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (out_a_valid !== 1'b0 || out_a_data !== 32'h0 || cnt_a !== 4'd0)
         begin errors++; $display("FAIL mid_rst_a got v=%0b d=%08h c=%0d exp v=0 d=0 c=0", out_a_valid, out_a_data, cnt_a); end
      checks++; if (out_b_valid !== 1'b0 || out_b_data !== 32'h0 || cnt_b !== 4'd0)
         begin errors++; $display("FAIL mid_rst_b got v=%0b d=%08h c=%0d exp v=0 d=0 c=0", out_b_valid, out_b_data, cnt_b); end
      tick();
      checks++; if (cnt_a !== 4'd0 || cnt_b !== 4'd0)
         begin errors++; $display("FAIL mid_no_count got a=%0d b=%0d exp 0 0", cnt_a, cnt_b); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_back_to_back();
      test_wrap();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
